// File: rtl/prmw_stage.sv
// -----------------------------------------------------------------------------
// prmw_stage
//
// MEM -> WB pipeline register. It captures the M-stage slot each cycle unless
// stalled or flushed, aligns and extends load data at capture time, selects the
// final writeback result from the registered fields, and counts retired
// instructions. Its outputs drive the register-file write port and the
// hazard/forwarding unit.
//
// Parameters
//   DATA_WIDTH  datapath width, 32 or 64
//   REG_ADDR_W  register index width
//   CNT_WIDTH   retired-instruction counter width (wraps modulo 2^CNT_WIDTH)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   stall_w      hold every W register
//   flush_w      load a bubble into W (wins over stall_w)
//   valid_m      M slot holds a real instruction
//   regwrite_m   register write enable
//   resultsrc_m  00 ALU, 01 load, 10 PC+4, 11 ALU
//   funct3_m     load type
//   aluresult_m  ALU result / memory address (low bits give the byte offset)
//   readdata_m   raw aligned memory word
//   rd_m         destination register
//   pcplus4_m    PC+4
//   valid_w      W slot valid
//   regwrite_w   registered regwrite, forced low for bubbles
//   resultsrc_w  registered resultsrc
//   aluresult_w  registered ALU result
//   readdata_w   extended load data
//   rd_w         registered destination register
//   pcplus4_w    registered PC+4
//   result_w     writeback value, combinational from W registers only
//   instret      retired-instruction count
// -----------------------------------------------------------------------------
module prmw_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic                  valid_m,
    input  logic                  regwrite_m,
    input  logic [1:0]            resultsrc_m,
    input  logic [2:0]            funct3_m,
    input  logic [DATA_WIDTH-1:0] aluresult_m,
    input  logic [DATA_WIDTH-1:0] readdata_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [DATA_WIDTH-1:0] pcplus4_m,
    output logic                  valid_w,
    output logic                  regwrite_w,
    output logic [1:0]            resultsrc_w,
    output logic [DATA_WIDTH-1:0] aluresult_w,
    output logic [DATA_WIDTH-1:0] readdata_w,
    output logic [REG_ADDR_W-1:0] rd_w,
    output logic [DATA_WIDTH-1:0] pcplus4_w,
    output logic [DATA_WIDTH-1:0] result_w,
    output logic [CNT_WIDTH-1:0]  instret
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam bit IS_64 = (DATA_WIDTH == 64);

    // W-stage registers
    logic                  r_valid;
    logic                  r_regwrite;
    logic [1:0]            r_resultsrc;
    logic [DATA_WIDTH-1:0] r_aluresult;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_pcplus4;
    logic [CNT_WIDTH-1:0]  r_instret;

    // Load alignment. The offset is kept 3 bits wide for both widths; at
    // 32-bit the top bit is forced to zero so the word select never moves.
    logic [2:0]            w_off;
    logic [5:0]            w_sh_byte;
    logic [5:0]            w_sh_half;
    logic [5:0]            w_sh_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_word;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_off     = IS_64 ? aluresult_m[2:0] : {1'b0, aluresult_m[1:0]};
    assign w_sh_byte = {w_off, 3'b000};
    // Halfword select ignores offset bit 0: misaligned halves are not trapped.
    assign w_sh_half = {w_off[2:1], 4'b0000};
    assign w_sh_word = {w_off[2], 5'b00000};

    assign w_byte = 8'(readdata_m >> w_sh_byte);
    assign w_half = 16'(readdata_m >> w_sh_half);
    assign w_word = 32'(readdata_m >> w_sh_word);

    // Extension runs for every capture; it only matters when resultsrc selects
    // load data, so no gating on resultsrc_m is needed.
    always_comb begin
        w_ext = readdata_m;
        case (funct3_m)
            F3_LB:  w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LBU: w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LH:  w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LHU: w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            F3_LW: begin
                if (IS_64) begin
                    w_ext = DATA_WIDTH'($signed(w_word));
                end
            end
            F3_LWU: begin
                // At 32-bit this encoding is undefined and passes the word.
                if (IS_64) begin
                    w_ext = DATA_WIDTH'(w_word);
                end
            end
            default: w_ext = readdata_m;
        endcase
    end

    // Flush shares the reset path so a flushed slot is indistinguishable from
    // a post-reset bubble, even while the stage is stalled.
    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_resultsrc <= 2'b00;
            r_aluresult <= '0;
            r_readdata  <= '0;
            r_rd        <= '0;
            r_pcplus4   <= '0;
        end else if (!stall_w) begin
            r_valid     <= valid_m;
            r_regwrite  <= regwrite_m & valid_m;
            r_resultsrc <= resultsrc_m;
            r_aluresult <= aluresult_m;
            r_readdata  <= w_ext;
            r_rd        <= rd_m;
            r_pcplus4   <= pcplus4_m;
        end
    end

    // The counter tracks the slot leaving W, so flush (which only kills the
    // incoming slot) does not suppress the increment; stall does.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_valid && !stall_w) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_result = r_aluresult;
        case (r_resultsrc)
            2'b01:   w_result = r_readdata;
            2'b10:   w_result = r_pcplus4;
            default: w_result = r_aluresult;
        endcase
    end

    assign valid_w     = r_valid;
    assign regwrite_w  = r_regwrite & r_valid;
    assign resultsrc_w = r_resultsrc;
    assign aluresult_w = r_aluresult;
    assign readdata_w  = r_readdata;
    assign rd_w        = r_rd;
    assign pcplus4_w   = r_pcplus4;
    assign result_w    = w_result;
    assign instret     = r_instret;

endmodule

// File: tb/tb_prmw_stage.sv
module tb_prmw_stage;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 32-bit instance, 64-bit counter
    logic        rst, stall_w, flush_w, valid_m, regwrite_m;
    logic [1:0]  resultsrc_m;
    logic [2:0]  funct3_m;
    logic [31:0] aluresult_m, readdata_m, pcplus4_m;
    logic [4:0]  rd_m;
    logic        valid_w, regwrite_w;
    logic [1:0]  resultsrc_w;
    logic [31:0] aluresult_w, readdata_w, pcplus4_w, result_w;
    logic [4:0]  rd_w;
    logic [63:0] instret;

    prmw_stage u_dut32 (
        .clk(clk), .rst(rst), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m),
        .funct3_m(funct3_m), .aluresult_m(aluresult_m), .readdata_m(readdata_m),
        .rd_m(rd_m), .pcplus4_m(pcplus4_m),
        .valid_w(valid_w), .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w),
        .aluresult_w(aluresult_w), .readdata_w(readdata_w), .rd_w(rd_w),
        .pcplus4_w(pcplus4_w), .result_w(result_w), .instret(instret)
    );

    // 64-bit instance, 4-bit counter
    logic        b_rst, b_stall_w, b_flush_w, b_valid_m, b_regwrite_m;
    logic [1:0]  b_resultsrc_m;
    logic [2:0]  b_funct3_m;
    logic [63:0] b_aluresult_m, b_readdata_m, b_pcplus4_m;
    logic [4:0]  b_rd_m;
    logic        b_valid_w, b_regwrite_w;
    logic [1:0]  b_resultsrc_w;
    logic [63:0] b_aluresult_w, b_readdata_w, b_pcplus4_w, b_result_w;
    logic [4:0]  b_rd_w;
    logic [3:0]  b_instret;

    prmw_stage #(.DATA_WIDTH(64), .REG_ADDR_W(5), .CNT_WIDTH(4)) u_dut64 (
        .clk(clk), .rst(b_rst), .stall_w(b_stall_w), .flush_w(b_flush_w),
        .valid_m(b_valid_m), .regwrite_m(b_regwrite_m), .resultsrc_m(b_resultsrc_m),
        .funct3_m(b_funct3_m), .aluresult_m(b_aluresult_m), .readdata_m(b_readdata_m),
        .rd_m(b_rd_m), .pcplus4_m(b_pcplus4_m),
        .valid_w(b_valid_w), .regwrite_w(b_regwrite_w), .resultsrc_w(b_resultsrc_w),
        .aluresult_w(b_aluresult_w), .readdata_w(b_readdata_w), .rd_w(b_rd_w),
        .pcplus4_w(b_pcplus4_w), .result_w(b_result_w), .instret(b_instret)
    );

    // 32-bit load table, readdata_m = 0x80FF7F01
    logic [2:0]  l32_f3  [8];
    logic [31:0] l32_adr [8];
    logic [31:0] l32_exp [8];

    // 64-bit load table, readdata_m = 0x80FF7F01_F00DBEEF
    logic [2:0]  l64_f3  [9];
    logic [63:0] l64_adr [9];
    logic [63:0] l64_exp [9];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        l32_f3[0] = 3'b000; l32_adr[0] = 32'h100; l32_exp[0] = 32'h00000001; // LB off0
        l32_f3[1] = 3'b000; l32_adr[1] = 32'h103; l32_exp[1] = 32'hFFFFFF80; // LB off3
        l32_f3[2] = 3'b100; l32_adr[2] = 32'h103; l32_exp[2] = 32'h00000080; // LBU off3
        l32_f3[3] = 3'b001; l32_adr[3] = 32'h102; l32_exp[3] = 32'hFFFF80FF; // LH off2
        l32_f3[4] = 3'b101; l32_adr[4] = 32'h103; l32_exp[4] = 32'h000080FF; // LHU off3
        l32_f3[5] = 3'b010; l32_adr[5] = 32'h100; l32_exp[5] = 32'h80FF7F01; // LW
        l32_f3[6] = 3'b110; l32_adr[6] = 32'h101; l32_exp[6] = 32'h80FF7F01; // 110 at 32-bit
        l32_f3[7] = 3'b011; l32_adr[7] = 32'h102; l32_exp[7] = 32'h80FF7F01; // 011

        l64_f3[0] = 3'b011; l64_adr[0] = 64'h0; l64_exp[0] = 64'h80FF7F01_F00DBEEF; // LD
        l64_f3[1] = 3'b010; l64_adr[1] = 64'h4; l64_exp[1] = 64'hFFFFFFFF_80FF7F01; // LW hi
        l64_f3[2] = 3'b110; l64_adr[2] = 64'h4; l64_exp[2] = 64'h00000000_80FF7F01; // LWU hi
        l64_f3[3] = 3'b010; l64_adr[3] = 64'h0; l64_exp[3] = 64'hFFFFFFFF_F00DBEEF; // LW lo
        l64_f3[4] = 3'b000; l64_adr[4] = 64'h7; l64_exp[4] = 64'hFFFFFFFF_FFFFFF80; // LB off7
        l64_f3[5] = 3'b001; l64_adr[5] = 64'h6; l64_exp[5] = 64'hFFFFFFFF_FFFF80FF; // LH off6
        l64_f3[6] = 3'b001; l64_adr[6] = 64'h7; l64_exp[6] = 64'hFFFFFFFF_FFFF80FF; // LH off7, bit0 ignored
        l64_f3[7] = 3'b101; l64_adr[7] = 64'h2; l64_exp[7] = 64'h00000000_0000F00D; // LHU off2
        l64_f3[8] = 3'b100; l64_adr[8] = 64'h5; l64_exp[8] = 64'h00000000_0000007F; // LBU off5

        // Both instances in reset with nonzero inputs
        rst = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        valid_m = 1'b1; regwrite_m = 1'b1; resultsrc_m = 2'b10; funct3_m = 3'b000;
        aluresult_m = 32'h1234; readdata_m = 32'hDEADBEEF; rd_m = 5'd7; pcplus4_m = 32'h88;
        b_rst = 1'b1; b_stall_w = 1'b0; b_flush_w = 1'b0;
        b_valid_m = 1'b1; b_regwrite_m = 1'b1; b_resultsrc_m = 2'b01; b_funct3_m = 3'b000;
        b_aluresult_m = 64'h0; b_readdata_m = 64'h80FF7F01_F00DBEEF; b_rd_m = 5'd1;
        b_pcplus4_m = 64'h4;
        step();
        step();
        check("rst_valid", valid_w, 0);
        check("rst_regwrite", regwrite_w, 0);
        check("rst_resultsrc", resultsrc_w, 0);
        check("rst_alu", aluresult_w, 0);
        check("rst_rdata", readdata_w, 0);
        check("rst_rd", rd_w, 0);
        check("rst_pc", pcplus4_w, 0);
        check("rst_result", result_w, 0);
        check("rst_instret", instret, 0);
        check("rst64_valid", b_valid_w, 0);
        check("rst64_instret", b_instret, 0);

        // First instruction after reset
        rst = 1'b0;
        valid_m = 1'b1; regwrite_m = 1'b1; rd_m = 5'd5; aluresult_m = 32'h10;
        resultsrc_m = 2'b00; funct3_m = 3'b010;
        step();
        check("first_rd", rd_w, 5);
        check("first_regwrite", regwrite_w, 1);
        check("first_result", result_w, 32'h10);
        check("first_valid", valid_w, 1);
        check("first_instret", instret, 0);

        // Load extension, 32-bit
        readdata_m = 32'h80FF7F01; resultsrc_m = 2'b01;
        for (int i = 0; i < 8; i++) begin
            funct3_m = l32_f3[i];
            aluresult_m = l32_adr[i];
            step();
            check($sformatf("ld32_rdata_%0d", i), readdata_w, l32_exp[i]);
            check($sformatf("ld32_result_%0d", i), result_w, l32_exp[i]);
        end
        check("ld32_instret", instret, 8);

        // Instruction A, then stall with B on the inputs
        valid_m = 1'b1; regwrite_m = 1'b1; rd_m = 5'd9; aluresult_m = 32'hA0;
        pcplus4_m = 32'hA4; resultsrc_m = 2'b00; funct3_m = 3'b010; readdata_m = 32'h11111111;
        step();
        check("a_instret", instret, 9);
        stall_w = 1'b1;
        rd_m = 5'd12; aluresult_m = 32'hB0; pcplus4_m = 32'hB4; resultsrc_m = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_rd_%0d", i), rd_w, 9);
            check($sformatf("stall_result_%0d", i), result_w, 32'hA0);
            check($sformatf("stall_instret_%0d", i), instret, 9);
        end
        check("stall_pc", pcplus4_w, 32'hA4);

        // Flush wins over stall
        flush_w = 1'b1;
        step();
        check("flush_valid", valid_w, 0);
        check("flush_regwrite", regwrite_w, 0);
        check("flush_rd", rd_w, 0);
        check("flush_alu", aluresult_w, 0);
        check("flush_rdata", readdata_w, 0);
        check("flush_pc", pcplus4_w, 0);
        check("flush_resultsrc", resultsrc_w, 0);
        check("flush_instret", instret, 9);

        // Bubble with regwrite set
        flush_w = 1'b0; stall_w = 1'b0;
        valid_m = 1'b0; regwrite_m = 1'b1; rd_m = 5'd3; resultsrc_m = 2'b00;
        step();
        check("bubble_regwrite", regwrite_w, 0);
        check("bubble_valid", valid_w, 0);
        step();
        check("bubble_instret", instret, 9);

        // Result mux
        valid_m = 1'b1; resultsrc_m = 2'b10; pcplus4_m = 32'h104; aluresult_m = 32'h55;
        step();
        check("mux_pc4", result_w, 32'h104);
        check("mux_instret0", instret, 9);
        resultsrc_m = 2'b11; aluresult_m = 32'h77;
        step();
        check("mux_alu11", result_w, 32'h77);
        check("mux_alu11_field", aluresult_w, 32'h77);
        check("mux_instret1", instret, 10);

        // 64-bit loads, counter wrap, mid-stream reset
        b_rst = 1'b0; b_resultsrc_m = 2'b01;
        for (int i = 0; i < 9; i++) begin
            b_funct3_m = l64_f3[i];
            b_aluresult_m = l64_adr[i];
            step();
            check($sformatf("ld64_rdata_%0d", i), b_readdata_w, l64_exp[i]);
            check($sformatf("ld64_result_%0d", i), b_result_w, l64_exp[i]);
        end
        check("cnt_after9", b_instret, 8);
        b_resultsrc_m = 2'b00;
        for (int i = 9; i < 17; i++) step();
        check("cnt_after17", b_instret, 0);
        step();
        check("cnt_wrap", b_instret, 1);
        b_rst = 1'b1;
        step();
        check("midrst_instret", b_instret, 0);
        check("midrst_valid", b_valid_w, 0);
        check("midrst_regwrite", b_regwrite_w, 0);
        b_rst = 1'b0;
        step();
        check("post_rst_instret", b_instret, 0);
        check("post_rst_valid", b_valid_w, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
